// File: rtl/xip_flash_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// xip_flash_responder
//
// SPI-flash responder (mode 0, single bit) that serves the SoC XIP flash port
// from a byte-wide memory read port. All SPI pins are oversampled in the clk_i
// domain; nothing is clocked by SCK.
//
// Commands: 0x03 read (24-bit address, unbounded, wrapping at 2^ADDR_BITS),
//           0x05 read status (STATUS_VAL repeated). Anything else is ignored.
//
// Ports:
//   clk_i, rstn_i     system clock, asynchronous active-low reset
//   spi_csn_i         chip select, active low (async)
//   spi_sck_i         SPI clock, mode 0 (async)
//   spi_mosi_i        serial data from initiator (async)
//   flash_nrst_i      flash nRESET, low holds the block idle
//   spi_miso_o        serial data to initiator
//   spi_miso_oe_o     MISO output enable
//   mem_rd_o          one-cycle memory read strobe
//   mem_addr_o        memory byte address
//   mem_data_i        read data, valid one clk after mem_rd_o
//
// ADDR_BITS must lie in 8..24.
// -----------------------------------------------------------------------------
module xip_flash_responder #(
    parameter int         ADDR_BITS  = 16,
    parameter logic [7:0] STATUS_VAL = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 spi_csn_i,
    input  logic                 spi_sck_i,
    input  logic                 spi_mosi_i,
    input  logic                 flash_nrst_i,
    output logic                 spi_miso_o,
    output logic                 spi_miso_oe_o,
    output logic                 mem_rd_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    input  logic [7:0]           mem_data_i
);

    // The shift register only keeps the bits that can reach the address; older
    // address bits simply fall off the top.
    localparam int                   SHIFT_W  = ADDR_BITS - 1;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_STATUS = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    logic [1:0]           csn_sync_r;
    logic [1:0]           sck_sync_r;
    logic [1:0]           mosi_sync_r;
    logic [1:0]           nrst_sync_r;
    logic                 csn_prev_r;
    logic                 sck_prev_r;

    logic                 csn_s;
    logic                 mosi_s;
    logic                 csn_fall_s;
    logic                 sck_rise_s;
    logic                 sck_fall_s;
    logic                 abort_s;
    logic [7:0]           cmd_byte_s;
    logic [ADDR_BITS-1:0] addr_full_s;

    state_t               state_r;
    state_t               state_next_s;

    logic [4:0]           bit_cnt_r;
    logic [2:0]           out_idx_r;
    logic [SHIFT_W-1:0]   shift_in_r;
    logic [7:0]           shift_out_r;
    logic [7:0]           next_byte_r;
    logic                 cap_r;
    logic                 miso_r;
    logic                 oe_r;
    logic                 mem_rd_r;
    logic [ADDR_BITS-1:0] mem_addr_r;

    // Two-flop synchronisers for all asynchronous pins, plus edge history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            csn_sync_r  <= 2'b11;
            sck_sync_r  <= 2'b00;
            mosi_sync_r <= 2'b00;
            nrst_sync_r <= 2'b00;
            csn_prev_r  <= 1'b1;
            sck_prev_r  <= 1'b0;
        end else begin
            csn_sync_r  <= {csn_sync_r[0], spi_csn_i};
            sck_sync_r  <= {sck_sync_r[0], spi_sck_i};
            mosi_sync_r <= {mosi_sync_r[0], spi_mosi_i};
            nrst_sync_r <= {nrst_sync_r[0], flash_nrst_i};
            csn_prev_r  <= csn_sync_r[1];
            sck_prev_r  <= sck_sync_r[1];
        end
    end

    assign csn_s       = csn_sync_r[1];
    assign mosi_s      = mosi_sync_r[1];
    assign csn_fall_s  = csn_prev_r & ~csn_s;
    assign sck_rise_s  = sck_sync_r[1] & ~sck_prev_r;
    assign sck_fall_s  = ~sck_sync_r[1] & sck_prev_r;
    assign abort_s     = csn_s | ~nrst_sync_r[1];
    // Byte/address as it will stand once the current rising edge is shifted in.
    assign cmd_byte_s  = {shift_in_r[6:0], mosi_s};
    assign addr_full_s = {shift_in_r, mosi_s};

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; deselect or flash reset wins from every state.
    always_comb begin
        state_next_s = state_r;
        if (abort_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (csn_fall_s) begin
                        state_next_s = ST_CMD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_s && (bit_cnt_r == 5'd7)) begin
                        case (cmd_byte_s)
                            8'h03:   state_next_s = ST_ADDR;
                            8'h05:   state_next_s = ST_STATUS;
                            default: state_next_s = ST_IGNORE;
                        endcase
                    end else begin
                        state_next_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sck_rise_s && (bit_cnt_r == 5'd23)) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_DATA:   state_next_s = ST_DATA;
                ST_STATUS: state_next_s = ST_STATUS;
                ST_IGNORE: state_next_s = ST_IGNORE;
                default:   state_next_s = ST_IDLE;
            endcase
        end
    end

    // Shift, memory-read and MISO datapath.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            bit_cnt_r   <= 5'd0;
            out_idx_r   <= 3'd7;
            shift_in_r  <= '0;
            shift_out_r <= 8'h00;
            next_byte_r <= 8'h00;
            cap_r       <= 1'b0;
            miso_r      <= 1'b0;
            oe_r        <= 1'b0;
            mem_rd_r    <= 1'b0;
            mem_addr_r  <= '0;
        end else begin
            mem_rd_r <= 1'b0;
            // Memory data arrives one cycle after the strobe is seen outside.
            cap_r    <= mem_rd_r;
            oe_r     <= (state_next_s == ST_DATA) || (state_next_s == ST_STATUS);
            if (cap_r) begin
                next_byte_r <= mem_data_i;
            end else begin
                next_byte_r <= next_byte_r;
            end

            if (abort_s) begin
                bit_cnt_r <= 5'd0;
                out_idx_r <= 3'd7;
                miso_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= 5'd0;
                        out_idx_r <= 3'd7;
                        miso_r    <= 1'b0;
                    end
                    ST_CMD: begin
                        if (sck_rise_s) begin
                            shift_in_r <= addr_full_s[SHIFT_W-1:0];
                            if (bit_cnt_r == 5'd7) begin
                                bit_cnt_r <= 5'd0;
                                if (cmd_byte_s == 8'h05) begin
                                    next_byte_r <= STATUS_VAL;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise_s) begin
                            shift_in_r <= addr_full_s[SHIFT_W-1:0];
                            if (bit_cnt_r == 5'd23) begin
                                bit_cnt_r  <= 5'd0;
                                out_idx_r  <= 3'd7;
                                mem_addr_r <= addr_full_s;
                                mem_rd_r   <= 1'b1;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_DATA, ST_STATUS: begin
                        if (sck_fall_s) begin
                            // Byte start: take the staged byte and, for reads,
                            // prefetch the following one while this one shifts.
                            if (out_idx_r == 3'd7) begin
                                miso_r      <= next_byte_r[7];
                                shift_out_r <= {next_byte_r[6:0], 1'b0};
                                if (state_r == ST_DATA) begin
                                    mem_addr_r <= mem_addr_r + ADDR_ONE;
                                    mem_rd_r   <= 1'b1;
                                end
                            end else begin
                                miso_r      <= shift_out_r[7];
                                shift_out_r <= {shift_out_r[6:0], 1'b0};
                            end
                            out_idx_r <= out_idx_r - 3'd1;
                        end
                    end
                    ST_IGNORE: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        miso_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi_miso_o    = miso_r;
    assign spi_miso_oe_o = oe_r;
    assign mem_rd_o      = mem_rd_r;
    assign mem_addr_o    = mem_addr_r;

endmodule

// File: tb/tb_xip_flash_responder.sv
`timescale 1ns/1ps
module tb_xip_flash_responder;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        spi_csn_i;
    logic        spi_sck_i;
    logic        spi_mosi_i;
    logic        flash_nrst_i;
    logic        spi_miso_o;
    logic        spi_miso_oe_o;
    logic        mem_rd_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_i = 8'h00;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_bytes [$];
    logic [15:0] exp_rd [$];

    int   n_checks   = 0;
    int   n_errors   = 0;
    bit   rx_active  = 1'b0;
    bit   oe_watch   = 1'b0;
    int   oe_hi_cnt  = 0;
    int   rx_cnt     = 0;
    logic [7:0] rx_byte = 8'h00;

    always #5 clk_i = ~clk_i;

    xip_flash_responder #(.ADDR_BITS(16), .STATUS_VAL(8'h00)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .spi_csn_i     (spi_csn_i),
        .spi_sck_i     (spi_sck_i),
        .spi_mosi_i    (spi_mosi_i),
        .flash_nrst_i  (flash_nrst_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .mem_rd_o      (mem_rd_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i)
    );

    // Memory model: data valid one clock after the strobe.
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_data_i <= mem[mem_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // MISO monitor: assembles bytes at SCK rising edges and scores them.
    always @(posedge spi_sck_i or posedge spi_csn_i) begin
        if (spi_csn_i) begin
            rx_cnt = 0;
        end else if (rx_active) begin
            check("oe_while_reading", {31'd0, spi_miso_oe_o}, 32'd1);
            rx_byte = {rx_byte[6:0], spi_miso_o};
            rx_cnt++;
            if (rx_cnt == 8) begin
                rx_cnt = 0;
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL miso_byte: got %0h with nothing expected", rx_byte);
                end else begin
                    check("miso_byte", {24'd0, rx_byte}, {24'd0, exp_bytes.pop_front()});
                end
            end
        end
    end

    // Read-strobe monitor and OE watcher, sampled on the falling clk edge.
    always @(negedge clk_i) begin
        if (mem_rd_o) begin
            if (exp_rd.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mem_rd: unexpected read at %0h", mem_addr_o);
            end else begin
                check("mem_rd_addr", {16'd0, mem_addr_o}, {16'd0, exp_rd.pop_front()});
            end
        end
        if (oe_watch && spi_miso_oe_o) oe_hi_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic sck_cycle(input logic b);
        spi_mosi_i = b;
        wait_clk(8);
        spi_sck_i = 1'b1;
        wait_clk(8);
        spi_sck_i = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sck_cycle(v[i]);
    endtask

    task automatic start_cmd(input logic [7:0] cmd);
        spi_csn_i = 1'b0;
        wait_clk(8);
        send_bits({16'd0, cmd}, 8);
    endtask

    task automatic start_read(input logic [23:0] a);
        start_cmd(8'h03);
        send_bits(a, 24);
    endtask

    // Data-phase clocks; the last one is left high so CS rises before its fall.
    task automatic data_clocks(input int n);
        rx_active  = 1'b1;
        spi_mosi_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_clk(8);
            spi_sck_i = 1'b1;
            wait_clk(8);
            if (i != n - 1) spi_sck_i = 1'b0;
        end
        rx_active = 1'b0;
    endtask

    task automatic end_frame();
        spi_csn_i = 1'b1;
        wait_clk(8);
        spi_sck_i = 1'b0;
        wait_clk(8);
        check("bytes_pending", exp_bytes.size(), 32'd0);
        check("reads_pending", exp_rd.size(), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, {31'd0, spi_miso_o}, 32'd0);
        check({tag, "_oe"},   {31'd0, spi_miso_oe_o}, 32'd0);
        check({tag, "_rd"},   {31'd0, mem_rd_o}, 32'd0);
        check({tag, "_addr"}, {16'd0, mem_addr_o}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rstn_i       = 1'b0;
        spi_csn_i    = 1'b1;
        spi_sck_i    = 1'b0;
        spi_mosi_i   = 1'b0;
        flash_nrst_i = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'hFFFF] = 8'hC3;
        mem[16'h0000] = 8'h7E;
        mem[16'h0020] = 8'h96;
        mem[16'h0021] = 8'h4B;

        wait_clk(4);
        check_outputs_zero("in_reset");
        rstn_i = 1'b1;
        wait_clk(4);
        check_outputs_zero("after_reset");

        // Basic read of two bytes.
        exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
        exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011); exp_rd.push_back(16'h0012);
        start_read(24'h000010);
        data_clocks(16);
        end_frame();

        // Address wrap from the top of memory to zero.
        exp_bytes.push_back(8'hC3); exp_bytes.push_back(8'h7E);
        exp_rd.push_back(16'hFFFF); exp_rd.push_back(16'h0000); exp_rd.push_back(16'h0001);
        start_read(24'h00FFFF);
        data_clocks(16);
        end_frame();

        // Read status: no memory traffic, OE held for the data phase.
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        start_cmd(8'h05);
        data_clocks(16);
        end_frame();

        // Unsupported command: OE never rises, no reads.
        oe_hi_cnt = 0;
        oe_watch  = 1'b1;
        start_cmd(8'h9F);
        send_bits(24'h000000, 16);
        end_frame();
        oe_watch = 1'b0;
        check("oe_in_ignored_frame", oe_hi_cnt, 32'd0);

        exp_bytes.push_back(8'hA5);
        exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011);
        start_read(24'h000010);
        data_clocks(8);
        end_frame();

        // CS raised after four data bits.
        exp_rd.push_back(16'h0020); exp_rd.push_back(16'h0021);
        start_read(24'h000020);
        data_clocks(4);
        check("oe_before_cs_rise", {31'd0, spi_miso_oe_o}, 32'd1);
        spi_csn_i = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_i);
            if (!spi_miso_oe_o && lat == 0) lat = i;
        end
        n_checks++;
        if (lat == 0 || lat > 3) begin
            n_errors++;
            $display("FAIL oe_drop_latency: got %0d clk want 1..3 (0 = never)", lat);
        end
        spi_sck_i = 1'b0;
        wait_clk(8);
        check("abort_reads_pending", exp_rd.size(), 32'd0);

        exp_bytes.push_back(8'h96);
        exp_rd.push_back(16'h0020); exp_rd.push_back(16'h0021);
        start_read(24'h000020);
        data_clocks(8);
        end_frame();

        // Flash reset pulse mid-address kills the frame.
        oe_hi_cnt = 0;
        oe_watch  = 1'b1;
        start_cmd(8'h03);
        send_bits(24'h000000, 10);
        flash_nrst_i = 1'b0;
        wait_clk(10);
        flash_nrst_i = 1'b1;
        send_bits(24'h000010, 14);
        send_bits(24'h000000, 8);
        end_frame();
        oe_watch = 1'b0;
        check("oe_after_flash_reset", oe_hi_cnt, 32'd0);

        exp_bytes.push_back(8'h4B);
        exp_rd.push_back(16'h0021); exp_rd.push_back(16'h0022);
        start_read(24'h000021);
        data_clocks(8);
        end_frame();

        // System reset in the middle of a data byte.
        exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011);
        start_read(24'h000010);
        data_clocks(4);
        check("oe_before_reset", {31'd0, spi_miso_oe_o}, 32'd1);
        rstn_i = 1'b0;
        #1;
        check_outputs_zero("mid_data_reset");
        spi_csn_i = 1'b1;
        spi_sck_i = 1'b0;
        wait_clk(4);
        rstn_i = 1'b1;
        wait_clk(8);
        check("final_reads_pending", exp_rd.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xip_flash_responder.md
Name: xip_flash_responder

Overview:
SPI-flash responder (mode 0, single-bit) that answers the XIP flash port of the SoC from a byte-wide memory read port. It lets the XIP path run in simulation and on FPGA builds without a physical flash. The CPU side drives CS/SCK/MOSI as an initiator and this block returns bytes on MISO. All SPI inputs are oversampled and synchronised to clk_i; no logic is clocked by SCK.

Parameters:
ADDR_BITS, 16, width of mem_addr_o; the low ADDR_BITS bits of the 24-bit SPI address are used.
STATUS_VAL, 8'h00, byte returned by the read-status command 0x05.

Ports:
clk_i  input  1  system clock
rstn_i  input  1  asynchronous active-low reset
spi_csn_i  input  1  chip select, active low (asynchronous to clk_i)
spi_sck_i  input  1  SPI clock, mode 0 (asynchronous)
spi_mosi_i  input  1  serial data from initiator (asynchronous)
flash_nrst_i  input  1  flash nRESET pin (xip_q3); low holds the block idle
spi_miso_o  output  1  serial data to initiator
spi_miso_oe_o  output  1  MISO output enable
mem_rd_o  output  1  one-cycle memory read strobe
mem_addr_o  output  ADDR_BITS  memory byte address
mem_data_i  input  8  read data, valid exactly 1 clk after mem_rd_o

Behaviour:
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, mem_rd_o=0, mem_addr_o=0, state=IDLE.
- Synchronisation: csn, sck and mosi each pass through 2-flop synchronisers. Edges are detected from the synchronised sck. Constraint: SCK high and low phases are each ≥6 clk_i cycles.
- csn deasserted (synchronised high) or flash_nrst_i low: go to IDLE in the next cycle from any state, oe_o=0, and discard any partial byte or address.
- Bit sampling: MOSI is sampled on each sck rising edge, MSB first. MISO updates on each sck falling edge.
- IDLE: on the csn falling edge, clear the bit counter and go to CMD.
- CMD: after 8 rising edges, decode the command byte.
  - 0x03 -> ADDR.
  - 0x05 -> STATUS; load the shift register with STATUS_VAL.
  - Any other value -> IGNORE.
- ADDR: shift in 24 bits. On the 24th rising edge:
  - latch addr[ADDR_BITS-1:0];
  - pulse mem_rd_o with mem_addr_o=addr;
  - capture mem_data_i into the shift register 1 cycle later;
  - go to DATA.
- DATA:
  - oe_o=1 from entry until exit.
  - The first falling edge after entry drives bit7. Each subsequent falling edge shifts to the next bit.
  - Prefetch: when bit7 goes out, increment the address modulo 2^ADDR_BITS and issue mem_rd_o. Latch the result into a next-byte register.
  - After bit0 has been driven, the next falling edge loads the next byte's bit7.
  - Reads are unbounded and wrap from 2^ADDR_BITS-1 to 0.
- STATUS: same shifting as DATA, with oe_o=1. The byte STATUS_VAL repeats for as long as CS stays low. No memory reads.
- IGNORE: oe_o=0, miso_o=0, wait for csn high.
- Latency: mem_rd_o is asserted ≤3 clk after the synchronised 24th address rising edge. This leaves data ready before the following falling edge under the SCK constraint.
- csn rising mid-byte: the partial byte is dropped; no further mem_rd_o; oe_o falls ≤3 clk after the csn edge.
- mem_rd_o is never asserted outside ADDR→DATA entry or DATA prefetch.

Test Plan:
- Memory preloaded with mem[0x0010]=0xA5, mem[0x0011]=0x3C. Send cmd 0x03, addr 0x000010, 16 clocks -> MISO returns 0xA5 then 0x3C; exactly 2 mem_rd_o pulses at 0x0010 and 0x0011 (3rd prefetch at 0x0012 allowed).
- Wrap: with ADDR_BITS=16, read from addr 0x00FFFF for 2 bytes -> returns mem[0xFFFF] then mem[0x0000].
- Cmd 0x05 with STATUS_VAL=8'h00, 16 clocks -> MISO=0x00,0x00; oe_o=1 throughout; no mem_rd_o.
- Cmd 0x9F (unsupported) -> oe_o stays 0 for the whole frame; no mem_rd_o. A following 0x03 frame works normally.
- CS raised after 4 data bits, new 0x03 frame at addr 0x000020 -> oe_o drops ≤3 clk after CS rises; new frame returns mem[0x0020].
- flash_nrst_i pulled low mid-address for 10 clk, then a full 0x03 frame -> first frame yields no mem_rd_o; second frame is correct. rstn_i asserted mid-DATA -> all outputs 0 immediately.
